// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder
//   Streaming MIPS instruction encoder. Each accepted beat (operation select
//   plus register/immediate fields) is assembled into a 32-bit MIPS word,
//   buffered in a small FIFO and written to consecutive word addresses of
//   instruction memory through a valid/ready write port.
//
// Ports
//   Clk, Reset            clock, asynchronous active-high reset
//   InValid / InReady     input beat handshake
//   InOp                  operation select (0..29 legal, 30..31 illegal)
//   InRs/InRt/InRd/InShamt register and shift fields
//   InImm                 [15:0] immediate/offset, [25:0] jump target
//   InLast                final instruction of a program
//   MemWrite / MemReady   memory write handshake
//   MemAddress            byte address {word address, 2'b00}
//   MemWriteData          encoded instruction at the FIFO head
//   Done                  one-cycle pulse after the last word is written
//   Error                 sticky illegal-operation flag
module mips_instr_encoder #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        InValid,
  output logic        InReady,
  input  logic [4:0]  InOp,
  input  logic [4:0]  InRs,
  input  logic [4:0]  InRt,
  input  logic [4:0]  InRd,
  input  logic [4:0]  InShamt,
  input  logic [25:0] InImm,
  input  logic        InLast,
  output logic        MemWrite,
  input  logic        MemReady,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        Done,
  output logic        Error
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] BASE_WORD = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state, state_next;
  logic [31:0]        fifo_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count, count_next;
  logic [ADDR_W-1:0]  word_addr;
  logic               accept, push, pop, full, empty, illegal;
  logic [31:0]        enc_word;

  // Field layout: opcode[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0].
  // Forced fields are substituted here so the FIFO only ever holds final words.
  function automatic logic [31:0] encode(
    input logic [4:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  sh,
    input logic [25:0] imm
  );
    logic [31:0] w;
    w = 32'h0;
    case (op)
      5'd0:  w = {6'd0,  rs,   rt,   rd,   sh,   6'd32};
      5'd1:  w = {6'd0,  rs,   rt,   rd,   sh,   6'd33};
      5'd2:  w = {6'd0,  rs,   rt,   rd,   sh,   6'd36};
      5'd3:  w = {6'd0,  rs,   rt,   rd,   sh,   6'd37};
      5'd4:  w = {6'd0,  rs,   rt,   rd,   sh,   6'd34};
      5'd5:  w = {6'd0,  rs,   rt,   rd,   sh,   6'd42};
      5'd6:  w = {6'd0,  rs,   rt,   rd,   sh,   6'd39};
      5'd7:  w = {6'd0,  5'd0, rt,   rd,   sh,   6'd0};
      5'd8:  w = {6'd0,  rs,   5'd0, 5'd0, 5'd0, 6'd8};
      5'd9:  w = {6'd0,  rs,   rt,   rd,   sh,   6'd10};
      5'd10: w = {6'd0,  5'd1, rt,   rd,   sh,   6'd2};
      5'd11: w = {6'd0,  rs,   rt,   rd,   5'd1, 6'd6};
      5'd12: w = {6'd0,  rs,   rt,   rd,   sh,   6'd38};
      5'd13: w = {6'd28, rs,   rt,   rd,   5'd0, 6'd33};
      5'd14: w = {6'd28, rs,   rt,   rd,   5'd0, 6'd32};
      5'd15: w = {6'd8,  rs,   rt,   imm[15:0]};
      5'd16: w = {6'd9,  rs,   rt,   imm[15:0]};
      5'd17: w = {6'd12, rs,   rt,   imm[15:0]};
      5'd18: w = {6'd13, rs,   rt,   imm[15:0]};
      5'd19: w = {6'd4,  rs,   rt,   imm[15:0]};
      5'd20: w = {6'd5,  rs,   rt,   imm[15:0]};
      5'd21: w = {6'd2,  imm};
      5'd22: w = {6'd3,  imm};
      5'd23: w = {6'd35, rs,   rt,   imm[15:0]};
      5'd24: w = {6'd43, rs,   rt,   imm[15:0]};
      5'd25: w = {6'd28, rs,   rt,   rd,   5'd0, 6'd2};
      5'd26: w = {6'd1,  rs,   5'd0, imm[15:0]};
      5'd27: w = {6'd1,  rs,   5'd1, imm[15:0]};
      5'd28: w = {6'd7,  rs,   5'd0, imm[15:0]};
      default: w = 32'h0;  // NOP, and a don't-care for illegal ops
    endcase
    return w;
  endfunction

  assign illegal  = (InOp[4:1] == 4'b1111);
  assign enc_word = encode(InOp, InRs, InRt, InRd, InShamt, InImm);

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Reset gates InReady combinationally so no beat is taken while held.
  assign InReady = !Reset && !full && (state == IDLE || state == RUN);
  assign accept  = InValid && InReady;
  assign push    = accept && !illegal;
  assign MemWrite = !empty;
  assign pop     = MemWrite && MemReady;

  assign MemWriteData = empty ? 32'h0 : fifo_mem[rd_ptr];
  assign MemAddress   = 32'({word_addr, 2'b00});
  assign Done         = (state == DONE);

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = InLast ? DRAIN : RUN;
      RUN:     if (accept && InLast) state_next = DRAIN;
      // Leave as soon as the FIFO will be empty so Done follows the final pop.
      DRAIN:   if (count_next == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      word_addr <= BASE_WORD;
      Error     <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (state == DONE)
        word_addr <= BASE_WORD;
      else if (pop)
        word_addr <= word_addr + ADDR_W'(1);
      if (accept && illegal) Error <= 1'b1;
    end
  end

  // FIFO storage is data only; the read side is masked while empty.
  always_ff @(posedge Clk) begin
    if (push) fifo_mem[wr_ptr] <= enc_word;
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: table-driven encodings plus
// hand-written handshake, backpressure, illegal-op, wrap and reset sequences.
module tb_mips_instr_encoder;
  localparam int DEPTH = 4;
  localparam int ADDR_W = 2;
  localparam int BASE_ADDR = 0;

  logic        Clk, Reset, InValid, InReady, InLast, MemWrite, MemReady, Done, Error;
  logic [4:0]  InOp, InRs, InRt, InRd, InShamt;
  logic [25:0] InImm;
  logic [31:0] MemAddress, MemWriteData;

  mips_instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .InOp(InOp), .InRs(InRs), .InRt(InRt), .InRd(InRd), .InShamt(InShamt),
    .InImm(InImm), .InLast(InLast), .MemWrite(MemWrite), .MemReady(MemReady),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData), .Done(Done), .Error(Error)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [4:0]  op, rs, rt, rd, sh;
    logic [25:0] imm;
    logic [31:0] word;
  } vec_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  vec_t tbl[$];
  wr_t  sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   next_addr = BASE_ADDR;
  int   done_cnt = 0;
  int   done_exp = 0;
  int   cyc = 0;
  logic [31:0] held_d, held_a;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Scoreboard consumer: every completed memory write is checked against the queue.
  always @(negedge Clk) begin
    wr_t e;
    if (!Reset && MemWrite === 1'b1 && MemReady) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", MemAddress, MemWriteData);
      end else begin
        e = sb.pop_front();
        check("wr_addr", MemAddress, e.addr);
        check("wr_data", MemWriteData, e.data);
      end
    end
    if (Done === 1'b1) done_cnt++;
  end

  // Present one beat and hold it until accepted; returns 1ns after the accepting edge.
  task automatic send(input logic [4:0] op, rs, rt, rd, sh, input logic [25:0] imm,
                      input logic last, input logic [31:0] word, input bit legal);
    int waits = 0;
    bit ok = 0;
    InOp = op; InRs = rs; InRt = rt; InRd = rd; InShamt = sh; InImm = imm;
    InLast = last; InValid = 1'b1;
    while (!ok && waits < 60) begin
      @(negedge Clk);
      if (InReady === 1'b1) begin
        ok = 1;
        if (legal) begin
          sb.push_back('{addr: 32'(next_addr * 4), data: word});
          next_addr = (next_addr + 1) % (1 << ADDR_W);
        end
        if (last) next_addr = BASE_ADDR;
      end
      @(posedge Clk); #1;
      waits++;
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: op %0d never accepted, got InReady %b expected 1", op, InReady);
    end
  endtask

  task automatic idle(input int n);
    InValid = 1'b0;
    InLast = 1'b0;
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic wait_done();
    int n = 0;
    InValid = 1'b0;
    done_exp++;
    while (done_cnt < done_exp && n < 50) begin @(posedge Clk); #1; n++; end
    @(posedge Clk); #1;
    check("done_count", done_cnt, done_exp);
  endtask

  task automatic addv(input logic [4:0] op, rs, rt, rd, sh, input logic [25:0] imm,
                      input logic [31:0] word);
    tbl.push_back('{op, rs, rt, rd, sh, imm, word});
  endtask

  task automatic addu(input logic [4:0] op, input logic [31:0] word);
    addv(op, 5'd6, 5'd2, 5'd3, 5'd4, 26'h3FF1234, word);
  endtask

  initial begin
    int t0;
    InValid = 0; InLast = 0; InOp = 0; InRs = 0; InRt = 0; InRd = 0; InShamt = 0;
    InImm = 0; MemReady = 1'b1; Reset = 1'b0;

    // Uniform fields rs=6 rt=2 rd=3 shamt=4 imm=0x3FF1234
    addu(5'd0,  32'h00C21920); addu(5'd1,  32'h00C21921); addu(5'd2,  32'h00C21924);
    addu(5'd3,  32'h00C21925); addu(5'd4,  32'h00C21922); addu(5'd5,  32'h00C2192A);
    addu(5'd6,  32'h00C21927); addu(5'd7,  32'h00021900); addu(5'd8,  32'h00C00008);
    addu(5'd9,  32'h00C2190A); addu(5'd10, 32'h00221902); addu(5'd11, 32'h00C21846);
    addu(5'd12, 32'h00C21926); addu(5'd13, 32'h70C21821); addu(5'd14, 32'h70C21820);
    addu(5'd15, 32'h20C21234); addu(5'd16, 32'h24C21234); addu(5'd17, 32'h30C21234);
    addu(5'd18, 32'h34C21234); addu(5'd19, 32'h10C21234); addu(5'd20, 32'h14C21234);
    addu(5'd21, 32'h0BFF1234); addu(5'd22, 32'h0FFF1234); addu(5'd23, 32'h8CC21234);
    addu(5'd24, 32'hACC21234); addu(5'd25, 32'h70C21802); addu(5'd26, 32'h04C01234);
    addu(5'd27, 32'h04C11234); addu(5'd28, 32'h1CC01234); addu(5'd29, 32'h00000000);
    addv(5'd10, 5'd0, 5'd5, 5'd4, 5'd3, 26'd0,    32'h002520C2);
    addv(5'd27, 5'd3, 5'd7, 5'd0, 5'd0, 26'hFFFE, 32'h0461FFFE);
    addv(5'd0,  5'd1, 5'd2, 5'd3, 5'd0, 26'd0,    32'h00221820);

    #1 Reset = 1'b1;
    repeat (3) @(negedge Clk);
    check("rst_inready", InReady, 0);
    check("rst_memwrite", MemWrite, 0);
    check("rst_addr", MemAddress, BASE_ADDR * 4);
    check("rst_data", MemWriteData, 0);
    check("rst_done", Done, 0);
    check("rst_error", Error, 0);
    @(posedge Clk); #1 Reset = 1'b0;
    @(negedge Clk);
    check("inready_after_rst", InReady, 1);
    @(posedge Clk); #1;

    // Single ADD, one-cycle latency from acceptance
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0, 1'b1, 32'h00221820, 1);
    check("lat_memwrite", MemWrite, 1);
    check("lat_data", MemWriteData, 32'h00221820);
    check("lat_addr", MemAddress, 0);
    wait_done();

    // Three-instruction program and Done timing
    send(5'd15, 5'd0, 5'd5, 5'd0, 5'd0, 26'hFFFF, 1'b0, 32'h2005FFFF, 1);
    send(5'd24, 5'd29, 5'd2, 5'd0, 5'd0, 26'd8, 1'b0, 32'hAFA20008, 1);
    send(5'd21, 5'd0, 5'd0, 5'd0, 5'd0, 26'h10, 1'b1, 32'h08000010, 1);
    InValid = 1'b0;
    @(negedge Clk);
    check("last_word_done", Done, 0);
    @(negedge Clk);
    check("done_pulse", Done, 1);
    check("done_inready", InReady, 0);
    check("done_memwrite", MemWrite, 0);
    @(negedge Clk);
    check("done_end", Done, 0);
    check("post_done_addr", MemAddress, 0);
    done_exp++;
    check("done_count", done_cnt, done_exp);
    @(posedge Clk); #1;

    // Table program, one beat per cycle
    t0 = cyc;
    for (int i = 0; i < tbl.size(); i++)
      send(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].sh, tbl[i].imm,
           (i == tbl.size() - 1), tbl[i].word, 1);
    check("throughput_cycles", 32'(cyc - t0), 32'(tbl.size()));
    wait_done();

    // Backpressure: 6 beats offered with memory stalled
    MemReady = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(5'd16, 5'd0, 5'(i), 5'd0, 5'd0, 26'(i), (i == 5),
               32'h24000000 | (32'(i) << 16) | 32'(i), 1);
        InValid = 1'b0;
      end
      begin
        repeat (8) @(negedge Clk);
        check("bp_accepted", 32'(sb.size()), 4);
        check("bp_inready", InReady, 0);
        check("bp_memwrite", MemWrite, 1);
        held_d = MemWriteData;
        held_a = MemAddress;
        check("bp_head_data", held_d, 32'h24000000);
        repeat (3) @(negedge Clk);
        check("bp_stable_data", MemWriteData, held_d);
        check("bp_stable_addr", MemAddress, held_a);
        @(posedge Clk); #1 MemReady = 1'b1;
        check("full_no_accept", InReady, 0);
      end
    join
    wait_done();

    // Illegal op: consumed, nothing written, sticky Error
    send(5'd31, 5'd1, 5'd1, 5'd1, 5'd1, 26'd1, 1'b0, 32'h0, 0);
    InValid = 1'b0;
    repeat (2) begin
      @(negedge Clk);
      check("illegal_no_write", MemWrite, 0);
    end
    check("illegal_error", Error, 1);
    @(posedge Clk); #1;
    send(5'd29, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b1, 32'h0, 1);
    wait_done();
    check("error_sticky", Error, 1);

    // Illegal last beat with FIFO empty: one DRAIN cycle, then Done
    send(5'd30, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b1, 32'h0, 0);
    InValid = 1'b0;
    @(negedge Clk);
    check("illegal_last_drain", Done, 0);
    check("illegal_last_nowrite", MemWrite, 0);
    @(negedge Clk);
    check("illegal_last_done", Done, 1);
    done_exp++;
    @(posedge Clk); #1;

    // Address wrap with ADDR_W=2: fifth word lands at byte address 0
    for (int i = 0; i < 5; i++)
      send(5'd18, 5'd0, 5'd1, 5'd0, 5'd0, 26'(16'hA000 + i), (i == 4),
           32'h34010000 | (32'hA000 + 32'(i)), 1);
    wait_done();

    // Reset mid-drain drops everything
    MemReady = 1'b0;
    send(5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0, 32'h0, 0);
    for (int i = 0; i < 3; i++)
      send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0, (i == 2), 32'h00221820, 1);
    InValid = 1'b0;
    @(posedge Clk); #3 Reset = 1'b1;
    #1;
    check("midrst_memwrite", MemWrite, 0);
    check("midrst_addr", MemAddress, 0);
    check("midrst_inready", InReady, 0);
    check("midrst_error", Error, 0);
    sb.delete();
    next_addr = BASE_ADDR;
    @(posedge Clk); #1 Reset = 1'b0;
    MemReady = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      check("post_rst_no_write", MemWrite, 0);
    end

    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
